// File: rtl/rmw_seq.sv
// rmw_seq: read-modify-write sequencer for 6502 memory-operand ASL/LSR/ROL/
// ROR/INC/DEC. It drives the NMOS bus pattern: read the operand, write the
// unmodified value back, then write the modified value. The shared ALU
// computes the new value, and N/Z/C are returned to the status register.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start/kind/addr/    request; sampled only when idle
//   carry_in
//   busy/done/err       status; done is a one-cycle pulse, err is valid with done
//   result, flag_*      modified byte and flag updates, valid with done
//   mem_*               byte-wide bus; mem_ready completes the current cycle
//   alu_*               shared ALU; alu_out/alu_status are one cycle behind
//                       the ALU inputs
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// READ  | operand read cycle
// DUMMY | write back the unmodified operand; ALU computes meanwhile
// WRITE | write the ALU result; flags captured on completion
// DONE  | done pulse, flag_c_we valid
// ERR   | illegal kind: done + err pulse, no bus activity
module rmw_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  kind,
  input  logic [15:0] addr,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_c_we,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [5:0]  alu_op,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_status
);

  // ALU operation codes, matching 6502_defs.vh.
  localparam logic [3:0] ALU_ASL = 4'h8;
  localparam logic [3:0] ALU_LSR = 4'h9;
  localparam logic [3:0] ALU_INC = 4'hC;
  localparam logic [3:0] ALU_DEC = 4'hD;
  // op[5] selects port b as the operand source; op[4] shifts alu_ci in.
  localparam logic [5:0] OP_B_SEL = 6'h20;
  localparam logic [5:0] OP_C_EN  = 6'h10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DUMMY,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [2:0]  kind_q;
  logic [7:0]  opnd;
  logic        wsel;   // high in WRITE: the bus takes its data straight from the ALU
  logic        unused_status;

  // Only N, Z and C are consumed from the ALU status byte.
  assign unused_status = ^alu_status[6:2];

  assign alu_ai = 8'h00;

  // The ALU result only becomes valid after the DUMMY->WRITE edge, so the
  // WRITE data cannot be registered; the ALU inputs are held constant
  // through WRITE, which keeps alu_out stable while the write waits.
  assign mem_wdata = wsel ? alu_out : (mem_wr ? opnd : 8'h00);

  function automatic logic [5:0] map_op(input logic [2:0] k);
    logic [5:0] op;
    op = 6'h00;
    case (k)
      3'd0:    op = OP_B_SEL | {2'b00, ALU_ASL};
      3'd1:    op = OP_B_SEL | {2'b00, ALU_LSR};
      3'd2:    op = OP_B_SEL | OP_C_EN | {2'b00, ALU_ASL};
      3'd3:    op = OP_B_SEL | OP_C_EN | {2'b00, ALU_LSR};
      3'd4:    op = OP_B_SEL | {2'b00, ALU_INC};
      3'd5:    op = OP_B_SEL | {2'b00, ALU_DEC};
      default: op = 6'h00;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind_q    <= 3'd0;
      opnd      <= 8'h00;
      wsel      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= 8'h00;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_c_we <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      alu_op    <= 6'h00;
      alu_bi    <= 8'h00;
      alu_ci    <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      flag_c_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (kind <= 3'd5) begin
              kind_q   <= kind;
              mem_addr <= addr;
              alu_ci   <= carry_in;
              mem_rd   <= 1'b1;
              state    <= READ;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        READ: begin
          if (mem_ready) begin
            opnd   <= mem_rdata;
            mem_rd <= 1'b0;
            mem_wr <= 1'b1;
            alu_bi <= mem_rdata;
            alu_op <= map_op(kind_q);
            state  <= DUMMY;
          end
        end
        DUMMY: begin
          if (mem_ready) begin
            wsel  <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            result    <= alu_out;
            flag_n    <= alu_status[7];
            flag_z    <= alu_status[1];
            flag_c    <= alu_status[0];
            flag_c_we <= (kind_q <= 3'd3);
            done      <= 1'b1;
            wsel      <= 1'b0;
            opnd      <= 8'h00;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            alu_op    <= 6'h00;
            alu_bi    <= 8'h00;
            alu_ci    <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmw_seq.sv
// Bench for rmw_seq: emulates the byte bus and the registered shared ALU,
// keeps queues of expected bus transfers and done reports computed from the
// instruction semantics, and checks the DUT against them every cycle.
module tb_rmw_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  kind;
  logic [15:0] addr;
  logic        carry_in;
  logic        busy, done, err;
  logic [7:0]  result;
  logic        flag_n, flag_z, flag_c, flag_c_we;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [5:0]  alu_op;
  logic [7:0]  alu_ai, alu_bi;
  logic        alu_ci;
  logic [7:0]  alu_out;
  logic [7:0]  alu_status;

  rmw_seq dut (
    .clk(clk), .rst(rst), .start(start), .kind(kind), .addr(addr),
    .carry_in(carry_in), .busy(busy), .done(done), .err(err),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_c_we(flag_c_we), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_ai(alu_ai),
    .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_out(alu_out),
    .alu_status(alu_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // External shared ALU: registered, one cycle of latency.
  function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [7:0] b,
                                        input logic ci);
    logic [7:0] r;
    logic       c;
    logic       cin;
    cin = op[4] & ci;
    r = 8'h00;
    c = 1'b0;
    case (op[3:0])
      4'h8: begin r = {b[6:0], cin}; c = b[7]; end
      4'h9: begin r = {cin, b[7:1]}; c = b[0]; end
      4'hC: r = b + 8'd1;
      4'hD: r = b - 8'd1;
      default: r = 8'h00;
    endcase
    return {r[7], 5'b00000, (r == 8'h00), c, r};
  endfunction

  always @(posedge clk) begin
    alu_out    <= alu_f(alu_op, alu_bi, alu_ci) [7:0];
    alu_status <= alu_f(alu_op, alu_bi, alu_ci) [15:8];
  end

  // Read data comes from a single bench-held byte; the address is checked
  // through the expected-bus queue.
  logic [7:0] rd_byte = 8'h00;
  assign mem_rdata = mem_rd ? rd_byte : 8'h00;

  typedef struct {
    bit         wr;
    logic [15:0] a;
    logic [7:0]  d;
  } bus_t;

  typedef struct {
    bit         e;
    logic [7:0] r;
    bit         n, z, c, cwe;
  } done_t;

  bus_t  busq[$];
  done_t donq[$];
  logic [7:0] model_result = 8'h00;

  // Captured at the done pulse for directed literal checks.
  logic [7:0] cap_res;
  logic       cap_n, cap_z, cap_c, cap_cwe, cap_err;
  int         done_cyc;

  // Instruction semantics: {cwe, n, z, c, value}.
  function automatic logic [11:0] rmw_exp(input logic [2:0] k, input logic [7:0] d,
                                          input logic ci);
    logic [7:0] v;
    logic       c;
    v = 8'h00;
    c = 1'b0;
    case (k)
      3'd0: begin v = d << 1; c = d[7]; end
      3'd1: begin v = d >> 1; c = d[0]; end
      3'd2: begin v = {d[6:0], ci}; c = d[7]; end
      3'd3: begin v = {ci, d[7:1]}; c = d[0]; end
      3'd4: v = d + 8'd1;
      3'd5: v = d - 8'd1;
      default: v = 8'h00;
    endcase
    return {(k <= 3'd3), v[7], (v == 8'h00), c, v};
  endfunction

  // Compare process.
  initial begin : monitor
    bit          hold_pend;
    logic [15:0] p_addr;
    logic        p_rd, p_wr;
    logic [7:0]  p_wdata;
    bus_t        b;
    done_t       dd;
    hold_pend = 0;
    p_addr = 16'h0;
    p_rd = 0;
    p_wr = 0;
    p_wdata = 8'h0;
    forever begin
      @(negedge clk);
      chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      chk("alu_ai_zero", {24'd0, alu_ai}, 32'd0);
      if (!busy || mem_rd) begin
        chk("alu_op_idle", {26'd0, alu_op}, 32'd0);
        chk("alu_bi_idle", {24'd0, alu_bi}, 32'd0);
      end
      if (hold_pend) begin
        chk("hold_addr", {16'd0, mem_addr}, {16'd0, p_addr});
        chk("hold_strobes", {30'd0, mem_rd, mem_wr}, {30'd0, p_rd, p_wr});
        if (p_wr) chk("hold_wdata", {24'd0, mem_wdata}, {24'd0, p_wdata});
      end
      if ((mem_rd || mem_wr) && mem_ready && !rst) begin
        if (busq.size() == 0) begin
          chk("bus_unexpected", {15'd0, mem_wr, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          b = busq.pop_front();
          chk("bus_kind", {31'd0, mem_wr}, {31'd0, b.wr});
          chk("bus_addr", {16'd0, mem_addr}, {16'd0, b.a});
          if (b.wr) chk("bus_wdata", {24'd0, mem_wdata}, {24'd0, b.d});
        end
      end
      if (done) begin
        cap_res = result;
        cap_n = flag_n;
        cap_z = flag_z;
        cap_c = flag_c;
        cap_cwe = flag_c_we;
        cap_err = err;
        done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        if (donq.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          dd = donq.pop_front();
          chk("done_err", {31'd0, err}, {31'd0, dd.e});
          chk("done_result", {24'd0, result}, {24'd0, dd.r});
          chk("done_c_we", {31'd0, flag_c_we}, {31'd0, dd.cwe});
          if (!dd.e) chk("done_nz", {30'd0, flag_n, flag_z}, {30'd0, dd.n, dd.z});
          if (dd.cwe) chk("done_c", {31'd0, flag_c}, {31'd0, dd.c});
        end
      end
      hold_pend = (mem_rd || mem_wr) && !mem_ready && !rst;
      p_addr = mem_addr;
      p_rd = mem_rd;
      p_wr = mem_wr;
      p_wdata = mem_wdata;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {22'd0, busy, done, err, mem_rd, mem_wr, flag_n, flag_z,
                        flag_c, flag_c_we, alu_ci}, 32'd0);
    chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_data"}, {2'd0, result, mem_wdata, alu_bi, alu_op}, 32'd0);
  endtask

  // One request. w = wait cycles inserted in each of READ, DUMMY and WRITE;
  // noise keeps start asserted from cycle 2 through the done cycle.
  task automatic run_op(input logic [2:0] k, input logic [15:0] a, input logic ci,
                        input logic [7:0] d, input int w, input bit noise,
                        output int lat);
    logic [11:0] ex;
    logic [5:0]  op_exp [0:5];
    bit          legal;
    bit          got;
    int          s;
    op_exp[0] = 6'h28; op_exp[1] = 6'h29; op_exp[2] = 6'h38;
    op_exp[3] = 6'h39; op_exp[4] = 6'h2C; op_exp[5] = 6'h2D;
    legal = (k <= 3'd5);
    ex = rmw_exp(k, d, ci);
    lat = -1;
    if (legal) begin
      busq.push_back('{wr: 1'b0, a: a, d: 8'h00});
      busq.push_back('{wr: 1'b1, a: a, d: d});
      busq.push_back('{wr: 1'b1, a: a, d: ex[7:0]});
      donq.push_back('{e: 1'b0, r: ex[7:0], n: ex[10], z: ex[9], c: ex[8], cwe: ex[11]});
      model_result = ex[7:0];
    end else begin
      donq.push_back('{e: 1'b1, r: model_result, n: 1'b0, z: 1'b0, c: 1'b0, cwe: 1'b0});
    end
    rd_byte = d;
    kind = k;
    addr = a;
    carry_in = ci;
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    got = 0;
    for (int n = 1; n <= 60 && !got; n++) begin
      mem_ready = (w == 0) ? 1'b1 : ((n % (w + 1)) == 0);
      if (noise && n >= 2) begin
        start = 1'b1;
        kind = 3'd0;
        addr = 16'hDEAD;
      end
      @(negedge clk);
      if (legal && n == w + 2) begin
        chk("dummy_alu_op", {26'd0, alu_op}, {26'd0, op_exp[k]});
        chk("dummy_alu_in", {23'd0, alu_ci, alu_bi}, {23'd0, ci, d});
      end
      if (done) begin
        got = 1;
        lat = done_cyc - s + 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    rst = 1'b1;
    start = 1'b0;
    kind = 3'd0;
    addr = 16'h0000;
    carry_in = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ASL 0x81 -> 0x02, C=1
    run_op(3'd0, 16'h0200, 1'b0, 8'h81, 0, 0, lat);
    chk("asl_latency", lat, 32'd4);
    chk("asl_result", {24'd0, cap_res}, 32'h02);
    chk("asl_flags", {28'd0, cap_n, cap_z, cap_c, cap_cwe}, 32'b0011);

    // ROR with carry in: 0x01 -> 0x80, N=1, C=1
    run_op(3'd3, 16'h1234, 1'b1, 8'h01, 0, 0, lat);
    chk("ror_result", {24'd0, cap_res}, 32'h80);
    chk("ror_flags", {28'd0, cap_n, cap_z, cap_c, cap_cwe}, 32'b1011);

    // INC wraps to zero; DEC wraps to 0xFF; neither writes C
    run_op(3'd4, 16'h00FF, 1'b1, 8'hFF, 0, 0, lat);
    chk("inc_result", {24'd0, cap_res}, 32'h00);
    chk("inc_nz_cwe", {29'd0, cap_n, cap_z, cap_cwe}, 32'b010);
    run_op(3'd5, 16'h8000, 1'b0, 8'h00, 0, 0, lat);
    chk("dec_result", {24'd0, cap_res}, 32'hFF);
    chk("dec_nz_cwe", {29'd0, cap_n, cap_z, cap_cwe}, 32'b100);

    // Remaining kinds and carry combinations, checked by the model.
    run_op(3'd1, 16'h0010, 1'b1, 8'h01, 0, 0, lat);
    chk("lsr_result", {24'd0, cap_res}, 32'h00);
    run_op(3'd2, 16'hFFFF, 1'b0, 8'h80, 0, 0, lat);
    run_op(3'd2, 16'h4321, 1'b1, 8'h00, 0, 0, lat);
    run_op(3'd0, 16'h0001, 1'b1, 8'h40, 0, 0, lat);

    // Three wait cycles per bus state, start held high while busy and in DONE.
    run_op(3'd2, 16'h0345, 1'b1, 8'h55, 3, 1, lat);
    chk("wait_latency", lat, 32'd13);
    chk("wait_result", {24'd0, cap_res}, 32'hAB);
    run_op(3'd5, 16'h0777, 1'b0, 8'h10, 1, 1, lat);
    chk("wait1_latency", lat, 32'd7);

    // Illegal kinds: done+err in cycle 1, no bus, result unchanged.
    run_op(3'd6, 16'h0999, 1'b0, 8'h33, 0, 0, lat);
    chk("err6_latency", lat, 32'd1);
    chk("err6_flags", {30'd0, cap_err, cap_cwe}, 32'b10);
    chk("err6_result", {24'd0, cap_res}, 32'h0F);
    run_op(3'd7, 16'h0999, 1'b1, 8'h33, 0, 0, lat);
    chk("err7_latency", lat, 32'd1);
    run_op(3'd1, 16'h0200, 1'b0, 8'hFE, 0, 0, lat);
    chk("after_err_latency", lat, 32'd4);
    chk("after_err_result", {24'd0, cap_res}, 32'h7F);

    // Reset in the first WRITE cycle: only the read and dummy write complete.
    busq.push_back('{wr: 1'b0, a: 16'h0300, d: 8'h00});
    busq.push_back('{wr: 1'b1, a: 16'h0300, d: 8'h40});
    rd_byte = 8'h40;
    kind = 3'd0;
    addr = 16'h0300;
    carry_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("write_wdata", {23'd0, mem_wr, mem_wdata}, 32'h180);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    model_result = 8'h00;
    @(negedge clk);
    check_zero("rst_mid");
    chk("rst_mid_busq", busq.size(), 32'd0);
    @(posedge clk);
    #1;
    run_op(3'd0, 16'h0300, 1'b0, 8'h40, 0, 0, lat);
    chk("after_rst_latency", lat, 32'd4);
    chk("after_rst_result", {24'd0, cap_res}, 32'h80);

    repeat (3) @(posedge clk);
    chk("busq_empty", busq.size(), 32'd0);
    chk("donq_empty", donq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
